// File: rtl/recepcao_medida_pkg.sv
// Shared constants for the ASCII measurement receiver: digit range and the
// FSM state encoding (the encoding is also exposed on db_estado).
package recepcao_medida_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NOVE = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DECODIFICA = 3'd1,
    ST_ACUMULA    = 3'd2,
    ST_ESPERA     = 3'd3,
    ST_FIM        = 3'd4,
    ST_ERRO       = 3'd5
  } estado_t;

endpackage

// File: rtl/recepcao_medida_fd.sv
// Datapath of the measurement receiver: byte register, digit counter,
// decimal accumulator (acc*10 + digit), output value register and, when
// RECEPCAO_TIMEOUT_EN is defined, the inter-byte timeout counter.
module recepcao_medida_fd
  import recepcao_medida_pkg::*;
#(
  parameter int N_DIGITOS      = 3,
  parameter int LARGURA        = 10,
  parameter logic [7:0] TERMINADOR = 8'h23,
  parameter int TIMEOUT_CICLOS = 5_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         dado_rx,
  input  logic               carrega_byte,
  input  logic               limpa,
  input  logic               acumula,
  input  logic               carrega_valor,
  input  logic               limpa_timeout,
  input  logic               conta_timeout,
  output logic [LARGURA-1:0] valor,
  output logic               eh_digito,
  output logic               eh_terminador,
  output logic               fim_contador,
  output logic               tem_digito,
  output logic               timeout
);

  localparam int LARG_CONT = $clog2(N_DIGITOS + 1);

  // Reject configurations where the largest frame value cannot fit in valor.
  if (N_DIGITOS < 1 || TIMEOUT_CICLOS < 1 ||
      (2 ** LARGURA) <= (10 ** N_DIGITOS - 1)) begin : g_parametros_invalidos
    $error("recepcao_medida_fd: invalid parameter combination");
  end

  logic [7:0]           byte_reg;
  logic [LARG_CONT-1:0] contador;
  logic [LARGURA-1:0]   acumulador;
  logic [LARGURA-1:0]   digito;

  assign digito        = LARGURA'(byte_reg[3:0]);
  assign eh_digito     = (byte_reg >= ASCII_ZERO) && (byte_reg <= ASCII_NOVE);
  assign eh_terminador = (byte_reg == TERMINADOR);
  assign fim_contador  = (contador == LARG_CONT'(N_DIGITOS));
  assign tem_digito    = (contador != '0);

  // Capture the incoming byte when the FSM accepts it.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) byte_reg <= '0;
    else if (carrega_byte) byte_reg <= dado_rx;
  end

  // Digit counter and decimal accumulator, cleared between frames.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador   <= '0;
      acumulador <= '0;
    end else if (limpa) begin
      contador   <= '0;
      acumulador <= '0;
    end else if (acumula) begin
      contador   <= contador + 1'b1;
      acumulador <= acumulador * LARGURA'(10) + digito;
    end
  end

  // Last good value; only a complete frame updates it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valor <= '0;
    else if (carrega_valor) valor <= acumulador;
  end

`ifdef RECEPCAO_TIMEOUT_EN
  localparam int LARG_TO = $clog2(TIMEOUT_CICLOS + 1);
  logic [LARG_TO-1:0] cont_timeout;

  // Count idle cycles spent waiting for the next byte of a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cont_timeout <= '0;
    else if (limpa_timeout) cont_timeout <= '0;
    else if (conta_timeout) cont_timeout <= cont_timeout + 1'b1;
  end

  assign timeout = (cont_timeout == LARG_TO'(TIMEOUT_CICLOS));
`else
  logic unused_timeout;
  assign unused_timeout = ^{limpa_timeout, conta_timeout};
  assign timeout        = 1'b0;
`endif

endmodule

// File: rtl/recepcao_medida.sv
// Receive end of the ASCII measurement link: parses 1..N_DIGITOS decimal
// digits closed by TERMINADOR, presents the binary value with a one-cycle
// pronto pulse, or a one-cycle erro pulse for a malformed frame.
// Optional build macro: RECEPCAO_TIMEOUT_EN enables the inter-byte timeout.
module recepcao_medida
  import recepcao_medida_pkg::*;
#(
  parameter int N_DIGITOS      = 3,
  parameter int LARGURA        = 10,
  parameter logic [7:0] TERMINADOR = 8'h23,
  parameter int TIMEOUT_CICLOS = 5_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         dado_rx,
  input  logic               pronto_rx,
  output logic [LARGURA-1:0] valor,
  output logic               pronto,
  output logic               erro,
  output logic [2:0]         db_estado
);

  estado_t estado;
  logic carrega_byte, limpa, acumula, carrega_valor, limpa_timeout, conta_timeout;
  logic eh_digito, eh_terminador, fim_contador, tem_digito, timeout;

  recepcao_medida_fd #(
    .N_DIGITOS     (N_DIGITOS),
    .LARGURA       (LARGURA),
    .TERMINADOR    (TERMINADOR),
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_fd (
    .clock        (clock),
    .reset        (reset),
    .dado_rx      (dado_rx),
    .carrega_byte (carrega_byte),
    .limpa        (limpa),
    .acumula      (acumula),
    .carrega_valor(carrega_valor),
    .limpa_timeout(limpa_timeout),
    .conta_timeout(conta_timeout),
    .valor        (valor),
    .eh_digito    (eh_digito),
    .eh_terminador(eh_terminador),
    .fim_contador (fim_contador),
    .tem_digito   (tem_digito),
    .timeout      (timeout)
  );

  // Datapath strobes decoded from the current state and pronto_rx.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    carrega_byte  = 1'b0;
    limpa         = 1'b0;
    acumula       = 1'b0;
    carrega_valor = 1'b0;
    limpa_timeout = 1'b0;
    conta_timeout = 1'b0;
    case (estado)
      ST_IDLE: begin
        limpa        = 1'b1;
        carrega_byte = pronto_rx;
      end
      ST_DECODIFICA: carrega_valor = eh_terminador && tem_digito;
      ST_ACUMULA: begin
        acumula       = 1'b1;
        limpa_timeout = 1'b1;
      end
      ST_ESPERA: begin
        carrega_byte  = pronto_rx;
        conta_timeout = !pronto_rx;
      end
      ST_ERRO: limpa = 1'b1;
      default: ;
    endcase
  end

  // Frame FSM with registered pronto/erro pulses aligned to FIM/ERRO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= ST_IDLE;
      pronto <= 1'b0;
      erro   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      case (estado)
        ST_IDLE: if (pronto_rx) estado <= ST_DECODIFICA;
        ST_DECODIFICA: begin
          if (eh_digito && !fim_contador) begin
            estado <= ST_ACUMULA;
          end else if (eh_terminador && tem_digito) begin
            estado <= ST_FIM;
            pronto <= 1'b1;
          end else begin
            estado <= ST_ERRO;
            erro   <= 1'b1;
          end
        end
        ST_ACUMULA: estado <= ST_ESPERA;
        ST_ESPERA: begin
          if (pronto_rx) begin
            estado <= ST_DECODIFICA;
          end else if (timeout) begin
            estado <= ST_ERRO;
            erro   <= 1'b1;
          end
        end
        default: estado <= ST_IDLE;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_recepcao_medida.sv
// Bench for recepcao_medida: a reference frame parser predicts each pronto or
// erro pulse (type, value, cycle) into a queue; a negedge monitor pops and
// compares whenever the DUT pulses. Define RECEPCAO_TIMEOUT_EN to add the
// timeout scenarios.
module tb_recepcao_medida;

  localparam int N_DIGITOS = 3;
  localparam int LARGURA   = 10;
  localparam int TIMEOUT   = 100;

  logic               clock = 1'b0;
  logic               reset;
  logic [7:0]         dado_rx;
  logic               pronto_rx;
  logic [LARGURA-1:0] valor;
  logic               pronto;
  logic               erro;
  logic [2:0]         db_estado;

  recepcao_medida #(
    .N_DIGITOS     (N_DIGITOS),
    .LARGURA       (LARGURA),
    .TERMINADOR    (8'h23),
    .TIMEOUT_CICLOS(TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .dado_rx  (dado_rx),
    .pronto_rx(pronto_rx),
    .valor    (valor),
    .pronto   (pronto),
    .erro     (erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit                 eh_erro;
    logic [LARGURA-1:0] valor;
    int                 due;     // expected cycle, -1 = not checked
  } evento_t;

  evento_t fila[$];
  int total = 0;
  int bad   = 0;
  int ciclo = 0;

  // reference parser state
  int                 m_cnt = 0;
  int                 m_acc = 0;
  logic [LARGURA-1:0] m_valor = '0;

  always @(posedge clock) ciclo++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pop and compare every pulse the DUT produces.
  always @(negedge clock) begin
    if (pronto === 1'b1 || erro === 1'b1) begin
      if (fila.size() == 0) begin
        check("pulso_inesperado", {30'd0, pronto, erro}, 32'd0);
      end else begin
        evento_t e;
        e = fila.pop_front();
        check("erro", erro, e.eh_erro);
        check("pronto", pronto, !e.eh_erro);
        check("valor", valor, e.valor);
        if (e.due >= 0) check("latencia", ciclo, e.due);
      end
    end
  end

  task automatic limpa_modelo();
    m_cnt = 0;
    m_acc = 0;
  endtask

  task automatic envia(input logic [7:0] b);
    int n;
    @(negedge clock);
    dado_rx   = b;
    pronto_rx = 1'b1;
    n = ciclo;
    if (b >= 8'h30 && b <= 8'h39 && m_cnt < N_DIGITOS) begin
      m_acc = m_acc * 10 + int'(b - 8'h30);
      m_cnt++;
    end else if (b == 8'h23 && m_cnt >= 1) begin
      m_valor = LARGURA'(m_acc);
      fila.push_back('{1'b0, m_valor, n + 2});
      limpa_modelo();
    end else begin
      fila.push_back('{1'b1, m_valor, n + 2});
      limpa_modelo();
    end
    @(negedge clock);
    pronto_rx = 1'b0;
    dado_rx   = 8'h00;
    repeat (4) @(negedge clock);
  endtask

  task automatic envia_str(input string s);
    for (int i = 0; i < s.len(); i++) envia(8'(s[i]));
  endtask

  task automatic espera_fila(input string tag);
    for (int i = 0; i < 200 && fila.size() != 0; i++) @(negedge clock);
    check({tag, "_fila_vazia"}, fila.size(), 0);
    check({tag, "_estado_idle"}, db_estado, 3'd0);
    check({tag, "_valor_mantido"}, valor, m_valor);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    pronto_rx = 1'b0;
    dado_rx   = 8'h00;
    #1;
    check("reset_valor", valor, 0);
    check("reset_pronto", pronto, 0);
    check("reset_erro", erro, 0);
    check("reset_estado", db_estado, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // three digits, maximum length
    envia_str("123#");
    espera_fila("t1");

    // single digit, then leading zeros
    envia_str("7#");
    envia_str("005#");
    espera_fila("t2");

    // back to 123, then a non-digit aborts; next frame still parses
    envia_str("123#");
    envia_str("1A");
    espera_fila("t3a");
    envia_str("45#");
    espera_fila("t3b");

    // too many digits, then terminator with no digits
    envia_str("1234");
    envia_str("#");
    espera_fila("t4");

    // reset mid-frame drops the partial frame and clears valor
    envia_str("12");
    @(negedge clock);
    reset = 1'b1;
    limpa_modelo();
    m_valor = '0;
    @(negedge clock);
    check("t5_reset_valor", valor, 0);
    check("t5_reset_estado", db_estado, 0);
    reset = 1'b0;
    envia_str("9#");
    espera_fila("t5");

    // largest value for three digits
    envia_str("999#");
    espera_fila("t7");

`ifdef RECEPCAO_TIMEOUT_EN
    // one digit, then silence: timeout raises erro, valor untouched
    envia(8'h31);
    fila.push_back('{1'b1, m_valor, -1});
    limpa_modelo();
    for (int i = 0; i < 150 && fila.size() != 0; i++) @(negedge clock);
    espera_fila("t6a");

    // a byte arriving just before the limit keeps the frame alive
    envia(8'h31);
    repeat (90) @(negedge clock);
    envia_str("2#");
    espera_fila("t6b");
`endif

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
